divider_multicycle: RTL and testbench

DIVIDER_MULTICYCLE -- requirements
Module: divider_multicycle

---
 rtl/divider_multicycle.sv | 129 ++++++++++++
 tb/tb_divider_multicycle.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/divider_multicycle.sv
// Multicycle 32-bit restoring divider, signed or unsigned, one quotient bit per cycle.
// Result packs remainder in c[63:32] and quotient in c[31:0]; done pulses for one cycle.
module divider_multicycle (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] c
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] abs_b_q, abs_b_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        dbz_q, dbz_d;
    logic [63:0] c_q, c_d;

    logic [32:0] trial;
    logic        fits;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // One restoring step. When the trial fits, the true difference is below 2^32,
    // so the low 32 bits of the subtraction are exact.
    always_comb begin
        trial    = {rem_q, quo_q[31]};
        fits     = (trial >= {1'b0, abs_b_q});
        step_rem = fits ? (trial[31:0] - abs_b_q) : trial[31:0];
        step_quo = {quo_q[30:0], fits};
        q_fix    = (sign_a_q ^ sign_b_q) ? -step_quo : step_quo;
        r_fix    = sign_a_q ? -step_rem : step_rem;
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        a_d      = a_q;
        abs_b_d  = abs_b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dbz_d    = dbz_q;
        c_d      = c_q;

        case (state_q)
            IDLE: begin
                if (valid) begin
                    a_d      = a;
                    sign_a_d = is_signed & a[31];
                    sign_b_d = is_signed & b[31];
                    quo_d    = (is_signed & a[31]) ? -a : a;
                    abs_b_d  = (is_signed & b[31]) ? -b : b;
                    dbz_d    = (b == 32'd0);
                    rem_d    = 32'd0;
                    cnt_d    = 6'd0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FIN;
                    // The final step and the sign fix-up land on the same edge as FIN.
                    c_d = dbz_q ? {a_q, 32'hFFFF_FFFF} : {r_fix, q_fix};
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge value of the others, matching real hardware.
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            a_q      <= 32'd0;
            abs_b_q  <= 32'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            c_q      <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            a_q      <= a_d;
            abs_b_q  <= abs_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dbz_q    <= dbz_d;
            c_q      <= c_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);
    assign c    = c_q;

endmodule

// File: tb/tb_divider_multicycle.sv
// Directed bench for divider_multicycle: a latency-level reference model checked every
// cycle, plus literal expectations for the canonical vectors and the robustness sequence.
module tb_divider_multicycle;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] c;

    int n_pass  = 0;
    int n_total = 0;

    divider_multicycle dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .c         (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Arithmetic definition of the result: truncating division, divide-by-zero override,
    // and the single signed overflow case.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        int          sx;
        int          sy;
        logic [31:0] q;
        logic [31:0] r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (!s) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sx = x;
        sy = y;
        q  = sx / sy;
        r  = sx % sy;
        return {r, q};
    endfunction

    // Timing reference: age counts cycles since acceptance; done in age 33, c lands then.
    int          m_age = 0;
    logic [63:0] m_res = '0;
    logic [63:0] m_c   = '0;
    bit          cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_age = 0;
            m_c   = '0;
        end else if (m_age == 0) begin
            if (valid) begin
                m_age = 1;
                m_res = model(a, b, is_signed);
            end
        end else if (m_age == 33) begin
            m_age = 0;
        end else begin
            m_age++;
            if (m_age == 33) m_c = m_res;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", {63'd0, busy}, {63'd0, m_age != 0});
            check("done", {63'd0, done}, {63'd0, m_age == 33});
            check("c",    c, m_c);
        end
    end

    // Issue one operation at the current negedge and wait for done; checks latency and c.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [63:0] exp, input string name);
        int k;
        valid     = 1'b1;
        a         = x;
        b         = y;
        is_signed = s;
        @(negedge clk);
        valid = 1'b0;
        a     = $urandom;
        b     = $urandom;
        k     = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({name, " latency"}, 64'(k), 64'd33);
        check({name, " result"}, c, exp);
        @(negedge clk);
    endtask

    initial begin
        resetn    = 1'b0;
        valid     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;

        check("model 100/7",     model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        check("model -7/2",      model(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("model 7/-2",      model(32'd7, 32'hFFFF_FFFE, 1'b1), {32'h1, 32'hFFFF_FFFD});
        check("model overflow",  model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h0, 32'h8000_0000});

        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset c", c, 64'h0);
        resetn = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, "u100/7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s-7/2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, "s7/-2");
        run_op(32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFF_FFFF}, "u5/0");
        run_op(32'd5, 32'd0, 1'b1, {32'd5, 32'hFFFF_FFFF}, "s5/0");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, "s_ovf");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, "u80000000/ffffffff");
        run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'd14}, "s-100/-7");

        // Robustness: a second request mid-operation must be ignored.
        valid     = 1'b1;
        a         = 32'd1000;
        b         = 32'd3;
        is_signed = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        valid     = 1'b1;
        a         = 32'd9;
        b         = 32'd2;
        is_signed = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        begin
            int k;
            k = 6;
            while (!done && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("ignored valid latency", 64'(k), 64'd33);
            check("ignored valid result", c, {32'd1, 32'd333});
        end
        @(negedge clk);

        // Reset during cycle 10 of a second operation aborts it with no done.
        valid     = 1'b1;
        a         = 32'd77;
        b         = 32'd5;
        is_signed = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("abort c", c, 64'h0);
        check("abort busy", {63'd0, busy}, 64'd0);
        begin
            bit seen;
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            check("abort no done", {63'd0, seen}, 64'd0);
        end

        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}, "uffffffff/1");
        repeat (3) @(negedge clk);
        check("hold c", c, {32'h0, 32'hFFFF_FFFF});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
